dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
// - Shares the byte-addressed data memory between two requesters: port 0 is the core load/store path, port 1 is the debug/DMA path.
// - Round-robin arbitration with valid/ready request and response handshakes.
// - Drives the memory Addr/DataW/MemRW/LenSel pins, sign- or zero-extends load data, and rejects misaligned, reserved-length and out-of-range accesses.
// PARAMETERS
// - WIDTH_ADDR_LENGTH  32       address width, both ports and memory side
// - WIDTH_DATA_LENGTH  32       data width
// - MEM_DEPTH          1<<10    memory size in bytes; used for the range check
// - LENGHT_MUX         2        width of len/LenSel
// PORTS
// - clk              in   1   clock; all state updates on posedge
// - rst_n            in   1   reset: synchronous, active-low
// - pN_req_valid     in   1   (N=0,1) request valid
// - pN_req_ready     out  1   request accepted this cycle when valid&ready
// - pN_addr          in   32  byte address
// - pN_wdata         in   32  store data; low bytes used per len
// - pN_we            in   1   1=store, 0=load
// - pN_len           in   2   00=byte, 01=half, 11=word, 10=reserved
// - pN_unsigned      in   1   loads: 1=zero-extend, 0=sign-extend
// - pN_rsp_valid     out  1   response valid; held until pN_rsp_ready
// - pN_rsp_ready     in   1   response consumed
// - pN_rdata         out  32  extended load data; 0 for stores and errors
// - pN_err           out  1   access rejected; memory not touched
// - dmem_addr        out  32  to memory Addr
// - dmem_dataw       out  32  to memory DataW
// - dmem_memrw       out  1   to memory MemRW; write takes effect at the posedge that ends ACCESS
// - dmem_lensel      out  2   to memory LenSel
// - dmem_datar       in   32  from memory DataR; combinational read of Addr..Addr+3
// BEHAVIOUR
// - FSM states: IDLE -> ACCESS -> RESP -> IDLE. One transaction is in flight at a time.
// - IDLE, arbitration:
//   - req_ready is asserted only in IDLE, and only to the granted port.
//   - If both ports are valid, grant the port not granted last. last_grant resets to 1, so port 0 wins the first tie.
//   - Single valid port: grant it.
//   - On accept, latch addr/wdata/we/len/unsigned/port into the command register and go to ACCESS.
// - ACCESS (exactly 1 cycle):
//   - dmem_* are driven from the command register; dmem_memrw = we & ~err.
//   - Load data from dmem_datar is extended and captured into the response register.
//   - Go to RESP.
// - RESP:
//   - rsp_valid is asserted on the owning port only.
//   - Stay until rsp_ready, then go to IDLE. No new accept happens in the RESP cycle.
// - Latency: accept at edge T; memory access during cycle T+1; rsp_valid from T+2. Peak throughput is 1 access per 3 cycles.
// - Error, evaluated at accept:
//   - len=10;
//   - len=01 with addr[0]=1;
//   - len=11 with addr[1:0]!=0;
//   - addr+bytes(len) > MEM_DEPTH.
//   - On error: ACCESS still occurs with dmem_memrw=0; the response has err=1 and rdata=0.
// - Load extension:
//   - byte: dmem_datar[7:0] extended with bit 7 (or zero);
//   - half: [15:0] extended with bit 15 (or zero);
//   - word: passed through.
// - Store: rsp_valid with rdata=0, err=0 once the write edge has passed.
// - Outside ACCESS: dmem_memrw=0; dmem_addr, dmem_dataw and dmem_lensel hold their last values.
// - Reset values: state=IDLE, last_grant=1; all req_ready, rsp_valid, err, rdata and dmem_* outputs are 0.
// - Reset mid-operation:
//   - rst_n low during ACCESS: the store still completes at that edge (memrw was already driven); the response is discarded.
//   - rst_n low during RESP: the pending response is dropped.
// - A requester that drops valid before ready is never granted. Requests are not queued.
// STRUCTURE
// - Shared header dmem_defs.vh: LEN_BYTE=2'b00, LEN_HALF=2'b01, LEN_WORD=2'b11; state encodings ST_IDLE/ST_ACCESS/ST_RESP.
// - Sub-module dmem_load_ext (combinational): inputs datar, len, unsigned; output 32-bit extended word. Reused by the core LSU.
// - Arbiter, FSM and check logic stay in this module.
// TESTING
// - Reset, then p0 stores word 0xDEADBEEF @0x10 -> accepted, memrw=1 for 1 cycle, rsp err=0; p0 loads word @0x10 -> rdata 0xDEADBEEF.
// - After byte 0x80 stored @0x21: load byte signed @0x21 -> 0xFFFFFF80; unsigned -> 0x00000080; half unsigned @0x20 -> 0x000080xx.
// - Both ports valid every cycle for 6 transactions -> grants p0,p1,p0,p1,p0,p1; nothing starved or lost.
// - Half @0x3, word @0x2, len=10, word @0x3FE -> each err=1, rdata=0, memrw never 1, memory unchanged.
// - Hold p1_rsp_ready=0 for 5 cycles -> rsp_valid and rdata stable; p0 req_ready stays 0 until the handshake.
// - Assert rst_n=0 during ACCESS of a store 0x11223344 @0x40 -> memory holds it; no rsp_valid; all outputs 0 next cycle.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter and the load extender:
// length encodings, FSM state type, per-transaction control bundle and a
// helper giving the byte count of an access length.
package dmem_arbiter_pkg;

  localparam logic [1:0] LEN_BYTE = 2'b00;
  localparam logic [1:0] LEN_HALF = 2'b01;
  localparam logic [1:0] LEN_RSVD = 2'b10;
  localparam logic [1:0] LEN_WORD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // Control half of the command register; addr/wdata live beside it
  // because their widths are module parameters.
  typedef struct packed {
    logic       port;
    logic       we;
    logic [1:0] len;
    logic       uns;
    logic       err;
  } cmd_ctl_t;

  // Reserved length reports 4 so the range check stays well defined;
  // the access is rejected by the length check anyway.
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      LEN_BYTE: len_bytes = 3'd1;
      LEN_HALF: len_bytes = 3'd2;
      default:  len_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/dmem_arbiter_load_ext.sv
// dmem_load_ext: combinational load-data extender, shared with the core LSU.
//   datar : raw memory read word (byte at Addr in bits [7:0])
//   len   : access length (byte / half / word)
//   uns   : 1 = zero-extend, 0 = sign-extend
//   ext   : extended result
module dmem_load_ext
  import dmem_arbiter_pkg::*;
#(
  parameter int WIDTH_DATA_LENGTH = 32,
  parameter int LENGHT_MUX        = 2
) (
  input  logic [WIDTH_DATA_LENGTH-1:0] datar,
  input  logic [LENGHT_MUX-1:0]        len,
  input  logic                         uns,
  output logic [WIDTH_DATA_LENGTH-1:0] ext
);

  always_comb begin
    ext = datar;
    case (len)
      LEN_BYTE: ext = {{(WIDTH_DATA_LENGTH-8){datar[7] & ~uns}}, datar[7:0]};
      LEN_HALF: ext = {{(WIDTH_DATA_LENGTH-16){datar[15] & ~uns}}, datar[15:0]};
      default:  ext = datar;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the byte-addressed data memory between port 0 (core
// load/store) and port 1 (debug/DMA). Round-robin grant, one transaction in
// flight (IDLE -> ACCESS -> RESP), access checks done at accept.
//   clk, rst_n            : clock, synchronous active-low reset
//   pN_req_*              : request handshake + addr/wdata/we/len/unsigned
//   pN_rsp_*, pN_rdata/err: response handshake, extended load data, reject flag
//   dmem_*                : memory Addr/DataW/MemRW/LenSel pins, DataR input
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int WIDTH_ADDR_LENGTH = 32,
  parameter int WIDTH_DATA_LENGTH = 32,
  parameter int MEM_DEPTH         = 1 << 10,
  parameter int LENGHT_MUX        = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         p0_req_valid,
  output logic                         p0_req_ready,
  input  logic [WIDTH_ADDR_LENGTH-1:0] p0_addr,
  input  logic [WIDTH_DATA_LENGTH-1:0] p0_wdata,
  input  logic                         p0_we,
  input  logic [LENGHT_MUX-1:0]        p0_len,
  input  logic                         p0_unsigned,
  output logic                         p0_rsp_valid,
  input  logic                         p0_rsp_ready,
  output logic [WIDTH_DATA_LENGTH-1:0] p0_rdata,
  output logic                         p0_err,
  input  logic                         p1_req_valid,
  output logic                         p1_req_ready,
  input  logic [WIDTH_ADDR_LENGTH-1:0] p1_addr,
  input  logic [WIDTH_DATA_LENGTH-1:0] p1_wdata,
  input  logic                         p1_we,
  input  logic [LENGHT_MUX-1:0]        p1_len,
  input  logic                         p1_unsigned,
  output logic                         p1_rsp_valid,
  input  logic                         p1_rsp_ready,
  output logic [WIDTH_DATA_LENGTH-1:0] p1_rdata,
  output logic                         p1_err,
  output logic [WIDTH_ADDR_LENGTH-1:0] dmem_addr,
  output logic [WIDTH_DATA_LENGTH-1:0] dmem_dataw,
  output logic                         dmem_memrw,
  output logic [LENGHT_MUX-1:0]        dmem_lensel,
  input  logic [WIDTH_DATA_LENGTH-1:0] dmem_datar
);

  state_e                         state_q, state_d;
  logic                           last_grant;
  cmd_ctl_t                       cmd;
  logic [WIDTH_ADDR_LENGTH-1:0]   cmd_addr;
  logic [WIDTH_DATA_LENGTH-1:0]   cmd_wdata;
  logic [WIDTH_DATA_LENGTH-1:0]   rsp_rdata;
  logic [WIDTH_DATA_LENGTH-1:0]   ext;

  logic                           sel_port, accept, rsp_ready_sel;
  logic [WIDTH_ADDR_LENGTH-1:0]   sel_addr;
  logic [WIDTH_DATA_LENGTH-1:0]   sel_wdata;
  logic [LENGHT_MUX-1:0]          sel_len;
  logic                           sel_we, sel_uns, sel_err;
  logic [WIDTH_ADDR_LENGTH:0]     sel_end;

  // Tie goes to the port not granted last; a lone requester always wins.
  assign sel_port = (p0_req_valid & p1_req_valid) ? ~last_grant : p1_req_valid;
  assign accept   = (state_q == ST_IDLE) & (p0_req_valid | p1_req_valid);

  assign p0_req_ready = accept & ~sel_port;
  assign p1_req_ready = accept &  sel_port;

  assign sel_addr  = sel_port ? p1_addr     : p0_addr;
  assign sel_wdata = sel_port ? p1_wdata    : p0_wdata;
  assign sel_we    = sel_port ? p1_we       : p0_we;
  assign sel_len   = sel_port ? p1_len      : p0_len;
  assign sel_uns   = sel_port ? p1_unsigned : p0_unsigned;

  // One extra bit so addr near the top of the address space cannot wrap
  // back into range.
  assign sel_end = {1'b0, sel_addr} + (WIDTH_ADDR_LENGTH+1)'(len_bytes(sel_len));

  assign sel_err = (sel_len == LEN_RSVD)
                 | ((sel_len == LEN_HALF) & sel_addr[0])
                 | ((sel_len == LEN_WORD) & (sel_addr[1:0] != 2'b00))
                 | (sel_end > (WIDTH_ADDR_LENGTH+1)'(MEM_DEPTH));

  assign rsp_ready_sel = cmd.port ? p1_rsp_ready : p0_rsp_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   if (rsp_ready_sel) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      cmd        <= '0;
      cmd_addr   <= '0;
      cmd_wdata  <= '0;
      rsp_rdata  <= '0;
    end else begin
      if (accept) begin
        last_grant <= sel_port;
        cmd        <= '{port: sel_port, we: sel_we, len: sel_len,
                        uns: sel_uns, err: sel_err};
        cmd_addr   <= sel_addr;
        cmd_wdata  <= sel_wdata;
      end
      if (state_q == ST_ACCESS)
        rsp_rdata <= (cmd.we | cmd.err) ? '0 : ext;
    end
  end

  dmem_load_ext #(
    .WIDTH_DATA_LENGTH(WIDTH_DATA_LENGTH),
    .LENGHT_MUX       (LENGHT_MUX)
  ) u_ext (
    .datar(dmem_datar),
    .len  (cmd.len),
    .uns  (cmd.uns),
    .ext  (ext)
  );

  // Memory pins come straight from the command register, so they only
  // change at accept and hold their last value otherwise.
  assign dmem_addr   = cmd_addr;
  assign dmem_dataw  = cmd_wdata;
  assign dmem_lensel = cmd.len;
  assign dmem_memrw  = (state_q == ST_ACCESS) & cmd.we & ~cmd.err;

  assign p0_rsp_valid = (state_q == ST_RESP) & ~cmd.port;
  assign p1_rsp_valid = (state_q == ST_RESP) &  cmd.port;
  assign p0_rdata     = p0_rsp_valid ? rsp_rdata : '0;
  assign p1_rdata     = p1_rsp_valid ? rsp_rdata : '0;
  assign p0_err       = p0_rsp_valid & cmd.err;
  assign p1_err       = p1_rsp_valid & cmd.err;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_req_valid, p0_req_ready, p0_we, p0_unsigned, p0_rsp_valid, p0_rsp_ready, p0_err;
  logic [31:0] p0_addr, p0_wdata, p0_rdata;
  logic [1:0]  p0_len;
  logic        p1_req_valid, p1_req_ready, p1_we, p1_unsigned, p1_rsp_valid, p1_rsp_ready, p1_err;
  logic [31:0] p1_addr, p1_wdata, p1_rdata;
  logic [1:0]  p1_len;
  logic [31:0] dmem_addr, dmem_dataw, dmem_datar;
  logic        dmem_memrw;
  logic [1:0]  dmem_lensel;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem     [0:1023];  // memory seen by the DUT
  logic [7:0] ref_mem [0:1023];  // expected memory contents
  bit         mem_ready = 1'b0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_we(p0_we), .p0_len(p0_len), .p0_unsigned(p0_unsigned),
    .p0_rsp_valid(p0_rsp_valid), .p0_rsp_ready(p0_rsp_ready), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_we(p1_we), .p1_len(p1_len), .p1_unsigned(p1_unsigned),
    .p1_rsp_valid(p1_rsp_valid), .p1_rsp_ready(p1_rsp_ready), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .dmem_addr(dmem_addr), .dmem_dataw(dmem_dataw), .dmem_memrw(dmem_memrw),
    .dmem_lensel(dmem_lensel), .dmem_datar(dmem_datar)
  );

  // Little-endian byte memory: combinational read, write at posedge.
  always_comb begin
    dmem_datar = '0;
    for (int i = 0; i < 4; i++)
      dmem_datar[8*i +: 8] = mem[10'(dmem_addr + 32'(i))];
  end

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 1024; i++) mem[i] = ref_mem[i];
      mem_ready = 1'b1;
    end else if (dmem_memrw) begin
      for (int i = 0; i < ((dmem_lensel == 2'b00) ? 1 : (dmem_lensel == 2'b01) ? 2 : 4); i++)
        mem[10'(dmem_addr + 32'(i))] = dmem_dataw[8*i +: 8];
    end
  end

  // Reference: applies the access rules directly to the byte array.
  function automatic void ref_access(input logic [31:0] a, input logic [31:0] wd,
                                     input logic we, input logic [1:0] len, input logic uns,
                                     output logic [31:0] rd, output logic er);
    int n;
    logic [63:0] v;
    n  = (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
    er = (len == 2'b10) || (len == 2'b01 && a % 2 != 0) || (len == 2'b11 && a % 4 != 0)
         || (64'(a) + 64'(n) > 64'd1024);
    rd = '0;
    if (!er) begin
      if (we) begin
        for (int i = 0; i < n; i++) ref_mem[a + 32'(i)] = wd[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < n; i++) v = v | (64'(ref_mem[a + 32'(i)]) << (8*i));
        if (!uns && v[8*n-1]) v = v | (~64'd0 << (8*n));
        rd = v[31:0];
      end
    end
  endfunction

  task automatic idle_inputs();
    p0_req_valid = 0; p1_req_valid = 0;
    p0_addr = 0; p0_wdata = 0; p0_we = 0; p0_len = 0; p0_unsigned = 0;
    p1_addr = 0; p1_wdata = 0; p1_we = 0; p1_len = 0; p1_unsigned = 0;
    p0_rsp_ready = 1; p1_rsp_ready = 1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic drive_port(input int p, input logic [31:0] a, input logic [31:0] wd,
                            input logic we, input logic [1:0] len, input logic uns);
    if (p == 0) begin
      p0_req_valid = 1; p0_addr = a; p0_wdata = wd; p0_we = we; p0_len = len; p0_unsigned = uns;
    end else begin
      p1_req_valid = 1; p1_addr = a; p1_wdata = wd; p1_we = we; p1_len = len; p1_unsigned = uns;
    end
  endtask

  // Runs one transaction on a single port; reports response, cycles from
  // accept edge to rsp_valid, number of memrw-high cycles, and timeout.
  task automatic issue(input int p, input logic [31:0] a, input logic [31:0] wd,
                       input logic we, input logic [1:0] len, input logic uns,
                       output logic [31:0] rd, output logic er, output int lat,
                       output int pulses, output bit to);
    int n;
    to = 0; pulses = 0; lat = 0; rd = '0; er = 0; n = 0;
    @(negedge clk);
    drive_port(p, a, wd, we, len, uns);
    #1;
    while (!(p == 1 ? p1_req_ready : p0_req_ready)) begin
      if (n > 20) begin to = 1; break; end
      @(negedge clk); #1; n++;
    end
    if (to) begin idle_inputs(); return; end
    @(posedge clk);
    @(negedge clk);
    p0_req_valid = 0; p1_req_valid = 0;
    lat = 1;
    while (!(p == 1 ? p1_rsp_valid : p0_rsp_valid)) begin
      if (lat >= 20) begin to = 1; break; end
      if (dmem_memrw) pulses++;
      @(negedge clk);
      lat++;
    end
    if (dmem_memrw) pulses++;
    rd = (p == 1) ? p1_rdata : p0_rdata;
    er = (p == 1) ? p1_err : p0_err;
    @(posedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 0;
    idle_inputs();
    @(posedge clk);
    @(negedge clk); #1;
    checks++; if ({p0_req_ready, p1_req_ready} !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b exp 00", {p0_req_ready, p1_req_ready}); end
    checks++; if ({p0_rsp_valid, p1_rsp_valid, p0_err, p1_err} !== 4'b0) begin errors++; $display("FAIL reset_rsp: got %b exp 0000", {p0_rsp_valid, p1_rsp_valid, p0_err, p1_err}); end
    checks++; if ((p0_rdata | p1_rdata) !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h/%h exp 0", p0_rdata, p1_rdata); end
    checks++; if ({dmem_addr, dmem_dataw, dmem_memrw, dmem_lensel} !== 67'h0) begin errors++; $display("FAIL reset_dmem: addr %h dataw %h memrw %b lensel %b exp all 0", dmem_addr, dmem_dataw, dmem_memrw, dmem_lensel); end
    repeat (1) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_store_load();
    logic [31:0] rd, erd; logic er, eer; int lat, pulses; bit to;
    issue(0, 32'h10, 32'hDEADBEEF, 1, 2'b11, 0, rd, er, lat, pulses, to);
    ref_access(32'h10, 32'hDEADBEEF, 1, 2'b11, 0, erd, eer);
    checks++; if (to) begin errors++; $display("FAIL store_word_timeout: got timeout exp response"); end
    checks++; if (er !== eer || rd !== erd) begin errors++; $display("FAIL store_word_rsp: got err %b rdata %h exp err %b rdata %h", er, rd, eer, erd); end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL store_word_memrw: got %0d cycles exp 1", pulses); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL store_word_latency: got %0d exp 2", lat); end
    issue(0, 32'h10, 32'h0, 0, 2'b11, 0, rd, er, lat, pulses, to);
    ref_access(32'h10, 32'h0, 0, 2'b11, 0, erd, eer);
    checks++; if (to || er !== eer || rd !== erd || erd !== 32'hDEADBEEF) begin errors++; $display("FAIL load_word: got err %b rdata %h exp err %b rdata %h", er, rd, eer, erd); end
    checks++; if (pulses !== 0 || lat !== 2) begin errors++; $display("FAIL load_word_timing: got memrw %0d lat %0d exp 0 2", pulses, lat); end
  endtask

  task automatic test_extension();
    logic [31:0] rd, erd; logic er, eer; int lat, pulses; bit to;
    logic [31:0] a [4]  = '{32'h21, 32'h21, 32'h21, 32'h20};
    logic        we [4] = '{1, 0, 0, 0};
    logic [1:0]  ln [4] = '{2'b00, 2'b00, 2'b00, 2'b01};
    logic        un [4] = '{0, 0, 1, 1};
    for (int i = 0; i < 4; i++) begin
      issue(0, a[i], 32'h0000_0080, we[i], ln[i], un[i], rd, er, lat, pulses, to);
      ref_access(a[i], 32'h0000_0080, we[i], ln[i], un[i], erd, eer);
      checks++; if (to || er !== eer || rd !== erd) begin errors++; $display("FAIL ext_%0d: got err %b rdata %h exp err %b rdata %h", i, er, rd, eer, erd); end
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd, erd; logic er, eer; int lat, pulses; bit to;
    logic [31:0] a [7]  = '{32'h3, 32'h2, 32'h8, 32'h3FE, 32'h3FF, 32'h3FC, 32'h3FF};
    logic        we [7] = '{0, 1, 1, 1, 1, 1, 1};
    logic [1:0]  ln [7] = '{2'b01, 2'b11, 2'b10, 2'b11, 2'b01, 2'b11, 2'b00};
    for (int i = 0; i < 7; i++) begin
      issue(i % 2, a[i], 32'hA5A5_5A5A, we[i], ln[i], 0, rd, er, lat, pulses, to);
      ref_access(a[i], 32'hA5A5_5A5A, we[i], ln[i], 0, erd, eer);
      checks++; if (to || er !== eer || rd !== erd) begin errors++; $display("FAIL err_case_%0d: got err %b rdata %h exp err %b rdata %h", i, er, rd, eer, erd); end
      checks++; if (pulses !== ((we[i] && !eer) ? 1 : 0)) begin errors++; $display("FAIL err_case_%0d_memrw: got %0d exp %0d", i, pulses, (we[i] && !eer) ? 1 : 0); end
    end
    check_mem("err_mem");
  endtask

  task automatic check_mem(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL %s: got %0d differing bytes exp 0", name, bad); end
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, a, wd; logic er, eer, we, un; logic [1:0] ln; int lat, pulses, p; bit to;
    for (int i = 0; i < 40; i++) begin
      p  = int'($urandom_range(0, 1));
      ln = 2'($urandom);
      we = 1'($urandom);
      un = 1'($urandom);
      wd = $urandom;
      a  = ($urandom_range(0, 7) == 0) ? $urandom_range(1018, 1030) : $urandom_range(0, 1023);
      if ($urandom_range(0, 3) != 0) a = a & ~32'h3;
      issue(p, a, wd, we, ln, un, rd, er, lat, pulses, to);
      ref_access(a, wd, we, ln, un, erd, eer);
      checks++; if (to || er !== eer || rd !== erd || lat !== 2) begin errors++; $display("FAIL rand_%0d p%0d a=%h len=%b we=%b: got err %b rdata %h lat %0d exp err %b rdata %h lat 2", i, p, a, ln, we, er, rd, lat, eer, erd); end
    end
    check_mem("rand_mem");
  endtask

  task automatic test_back_to_back();
    int gnt_q[$];
    int idx [2];
    int nresp, cyc, exp_p;
    bit pend;
    logic [31:0] erd, rd; logic eer, er;
    apply_reset();
    idx = '{0, 0}; nresp = 0; cyc = 0; pend = 0; exp_p = 0; erd = 0; eer = 0;
    while (nresp < 6 && cyc < 200) begin
      p0_req_valid = (idx[0] < 3); p0_addr = 32'h100 + 32'(4*idx[0]);
      p0_wdata = 32'hC0DE_0000 + 32'(idx[0]); p0_we = 1; p0_len = 2'b11; p0_unsigned = 0;
      p1_req_valid = (idx[1] < 3); p1_addr = 32'h100 + 32'(4*idx[1]);
      p1_wdata = 32'h0; p1_we = 0; p1_len = 2'b11; p1_unsigned = 0;
      #1;
      if (p0_rsp_valid || p1_rsp_valid) begin
        rd = p1_rsp_valid ? p1_rdata : p0_rdata;
        er = p1_rsp_valid ? p1_err : p0_err;
        checks++; if (!pend || (p1_rsp_valid ? 1 : 0) != exp_p || rd !== erd || er !== eer) begin errors++; $display("FAIL b2b_rsp_%0d: got port %0d err %b rdata %h exp port %0d err %b rdata %h", nresp, p1_rsp_valid ? 1 : 0, er, rd, exp_p, eer, erd); end
        nresp++; pend = 0;
      end
      if (p0_req_ready && p1_req_ready) begin
        checks++; errors++; $display("FAIL b2b_dual_ready: got both ready exp one");
      end
      if (p0_req_valid && p0_req_ready) begin
        gnt_q.push_back(0); ref_access(p0_addr, p0_wdata, 1, 2'b11, 0, erd, eer);
        pend = 1; exp_p = 0; idx[0]++;
      end else if (p1_req_valid && p1_req_ready) begin
        gnt_q.push_back(1); ref_access(p1_addr, 32'h0, 0, 2'b11, 0, erd, eer);
        pend = 1; exp_p = 1; idx[1]++;
      end
      @(negedge clk);
      cyc++;
    end
    idle_inputs();
    checks++; if (nresp != 6) begin errors++; $display("FAIL b2b_count: got %0d responses exp 6", nresp); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (i >= gnt_q.size() || gnt_q[i] != i % 2) begin errors++; $display("FAIL b2b_grant_%0d: got %0d exp %0d", i, (i < gnt_q.size()) ? gnt_q[i] : -1, i % 2); end
    end
    check_mem("b2b_mem");
  endtask

  task automatic test_rsp_hold();
    logic [31:0] erd; logic eer;
    bit to;
    int n;
    to = 0; n = 0;
    @(negedge clk);
    p1_rsp_ready = 0;
    drive_port(1, 32'h100, 32'h0, 0, 2'b11, 0);
    #1;
    while (!p1_req_ready) begin
      if (n > 20) begin to = 1; break; end
      @(negedge clk); #1; n++;
    end
    checks++; if (to) begin errors++; $display("FAIL hold_accept: got timeout exp accept"); end
    ref_access(32'h100, 32'h0, 0, 2'b11, 0, erd, eer);
    @(posedge clk);
    @(negedge clk);
    p1_req_valid = 0;
    drive_port(0, 32'h200, 32'h77, 1, 2'b00, 0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (p1_rsp_valid !== 1'b1 || p1_rdata !== erd || p0_req_ready !== 1'b0) begin errors++; $display("FAIL hold_cycle_%0d: got valid %b rdata %h p0_ready %b exp valid 1 rdata %h p0_ready 0", i, p1_rsp_valid, p1_rdata, p0_req_ready, erd); end
      @(negedge clk);
    end
    p1_rsp_ready = 1;
    @(posedge clk);
    @(negedge clk); #1;
    checks++; if (p1_rsp_valid !== 1'b0 || p0_req_ready !== 1'b1) begin errors++; $display("FAIL hold_release: got p1 valid %b p0 ready %b exp 0 1", p1_rsp_valid, p0_req_ready); end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    logic [31:0] erd, w; logic eer;
    @(negedge clk);
    drive_port(0, 32'h40, 32'h11223344, 1, 2'b11, 0);
    @(posedge clk);
    @(negedge clk);
    p0_req_valid = 0;
    checks++; if (dmem_memrw !== 1'b1) begin errors++; $display("FAIL rstmid_memrw: got %b exp 1", dmem_memrw); end
    rst_n = 0;
    ref_access(32'h40, 32'h11223344, 1, 2'b11, 0, erd, eer);
    @(posedge clk);
    @(negedge clk); #1;
    w = {mem[32'h43], mem[32'h42], mem[32'h41], mem[32'h40]};
    checks++; if (w !== 32'h11223344) begin errors++; $display("FAIL rstmid_mem: got %h exp 11223344", w); end
    checks++; if ({p0_rsp_valid, p1_rsp_valid, p0_req_ready, p1_req_ready, p0_err, p1_err} !== 6'b0 || (p0_rdata | p1_rdata) !== 32'h0) begin errors++; $display("FAIL rstmid_outputs: got rsp %b%b rdy %b%b err %b%b exp all 0", p0_rsp_valid, p1_rsp_valid, p0_req_ready, p1_req_ready, p0_err, p1_err); end
    checks++; if ({dmem_addr, dmem_dataw, dmem_memrw, dmem_lensel} !== 67'h0) begin errors++; $display("FAIL rstmid_dmem: addr %h dataw %h memrw %b lensel %b exp all 0", dmem_addr, dmem_dataw, dmem_memrw, dmem_lensel); end
    rst_n = 1;
    repeat (3) begin
      @(negedge clk); #1;
      checks++; if (p0_rsp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_dropped: got rsp_valid %b exp 0", p0_rsp_valid); end
    end
    check_mem("rstmid_mem");
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'($urandom);
    rst_n = 0;
    idle_inputs();
    test_reset();
    test_store_load();
    test_extension();
    test_errors();
    test_random();
    test_back_to_back();
    test_rsp_hold();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish exp finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
